// File: rtl/gpio_port.sv
// 16-bit MSP430 GPIO port (P1 = bits 7:0, P2 = bits 15:8) at base 0x0200 with per-port edge interrupts.
// Define GPIO_SYNC_EN to add a two-flop synchronizer on pad_in ahead of PAIN and edge detection.
module gpio_port (
    input  logic        SysClock,
    input  logic        rst_n,
    input  logic [15:0] MAB,
    input  logic [15:0] MDB_in,
    output logic [15:0] MDB_out,
    input  logic        MW,
    input  logic        MR,
    input  logic        BW,
    input  logic [15:0] pad_in,
    output logic [15:0] pad_out,
    output logic [15:0] padir,
    output logic [15:0] paren,
    output logic        int_p1,
    output logic        int_p2
);

    localparam logic [4:0] OFF_IN   = 5'h00;
    localparam logic [4:0] OFF_OUT  = 5'h02;
    localparam logic [4:0] OFF_DIR  = 5'h04;
    localparam logic [4:0] OFF_REN  = 5'h06;
    localparam logic [4:0] OFF_P1IV = 5'h0E;
    localparam logic [4:0] OFF_IES  = 5'h18;
    localparam logic [4:0] OFF_IE   = 5'h1A;
    localparam logic [4:0] OFF_IFG  = 5'h1C;
    localparam logic [4:0] OFF_P2IV = 5'h1E;

    logic [15:0] pain;
    logic [15:0] prev;
    logic [15:0] out_q;
    logic [15:0] dir_q;
    logic [15:0] ren_q;
    logic [15:0] ies_q;
    logic [15:0] ie_q;
    logic [15:0] ifg_q;
    logic [15:0] ifg_next;
    logic [15:0] edge_set;
    logic [15:0] rword;
    logic [15:0] wmask;
    logic [15:0] wdata;
    logic [4:0]  off;
    logic        legal;
    logic        wr;
    logic        rd;
    logic        byte_hi;

    // Word accesses to odd addresses never decode.
    assign legal   = (MAB[15:5] == 11'h010) && (BW || !MAB[0]);
    assign off     = {MAB[4:1], 1'b0};
    assign wr      = MW && legal;
    assign rd      = MR && legal;
    assign byte_hi = BW && MAB[0];
    assign wmask   = BW ? (MAB[0] ? 16'hFF00 : 16'h00FF) : 16'hFFFF;
    assign wdata   = BW ? {MDB_in[7:0], MDB_in[7:0]} : MDB_in;

    function automatic logic [15:0] merge(input logic [15:0] old_v, input logic [15:0] new_v,
                                          input logic [15:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    // Vector value 2*(k+1) for the lowest set flag k; bit 0 has highest priority.
    function automatic logic [15:0] iv_value(input logic [7:0] f);
        logic [15:0] v;
        v = 16'h0000;
        for (int i = 7; i >= 0; i--) begin
            if (f[i]) v = 16'((i + 1) * 2);
        end
        return v;
    endfunction

    function automatic logic [7:0] lowest_bit(input logic [7:0] f);
        return f & (~f + 8'd1);
    endfunction

`ifdef GPIO_SYNC_EN
    logic [15:0] meta;
    always_ff @(posedge SysClock or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 16'h0000;
            pain <= 16'h0000;
        end else begin
            meta <= pad_in;
            pain <= meta;
        end
    end
`else
    always_ff @(posedge SysClock or negedge rst_n) begin
        if (!rst_n) pain <= 16'h0000;
        else        pain <= pad_in;
    end
`endif

    assign edge_set = (pain & ~prev & ~ies_q) | (~pain & prev & ies_q);

    // Software clears and writes first; a hardware edge on the same clock always wins.
    always_comb begin
        ifg_next = ifg_q;
        if (wr && off == OFF_IFG)  ifg_next = merge(ifg_q, wdata, wmask);
        if (wr && off == OFF_P1IV) ifg_next[7:0] = 8'h00;
        if (wr && off == OFF_P2IV) ifg_next[15:8] = 8'h00;
        if (rd && !byte_hi && off == OFF_P1IV)
            ifg_next[7:0] = ifg_next[7:0] & ~lowest_bit(ifg_q[7:0]);
        if (rd && !byte_hi && off == OFF_P2IV)
            ifg_next[15:8] = ifg_next[15:8] & ~lowest_bit(ifg_q[15:8]);
        ifg_next = ifg_next | edge_set;
    end

    always_ff @(posedge SysClock or negedge rst_n) begin
        if (!rst_n) begin
            prev  <= 16'h0000;
            out_q <= 16'h0000;
            dir_q <= 16'h0000;
            ren_q <= 16'h0000;
            ies_q <= 16'h0000;
            ie_q  <= 16'h0000;
            ifg_q <= 16'h0000;
        end else begin
            prev  <= pain;
            ifg_q <= ifg_next;
            if (wr) begin
                case (off)
                    OFF_OUT: out_q <= merge(out_q, wdata, wmask);
                    OFF_DIR: dir_q <= merge(dir_q, wdata, wmask);
                    OFF_REN: ren_q <= merge(ren_q, wdata, wmask);
                    OFF_IES: ies_q <= merge(ies_q, wdata, wmask);
                    OFF_IE:  ie_q  <= merge(ie_q, wdata, wmask);
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rword = 16'h0000;
        case (off)
            OFF_IN:   rword = pain;
            OFF_OUT:  rword = out_q;
            OFF_DIR:  rword = dir_q;
            OFF_REN:  rword = ren_q;
            OFF_P1IV: rword = iv_value(ifg_q[7:0]);
            OFF_IES:  rword = ies_q;
            OFF_IE:   rword = ie_q;
            OFF_IFG:  rword = ifg_q;
            OFF_P2IV: rword = iv_value(ifg_q[15:8]);
            default:  rword = 16'h0000;
        endcase
    end

    always_comb begin
        MDB_out = 16'h0000;
        if (legal) begin
            if (!BW)         MDB_out = rword;
            else if (MAB[0]) MDB_out = {8'h00, rword[15:8]};
            else             MDB_out = {8'h00, rword[7:0]};
        end
    end

    assign pad_out = out_q;
    assign padir   = dir_q;
    assign paren   = ren_q;
    assign int_p1  = |(ifg_q[7:0] & ie_q[7:0]);
    assign int_p2  = |(ifg_q[15:8] & ie_q[15:8]);

endmodule

// File: tb/tb_gpio_port.sv
// Scoreboard bench for gpio_port: drivers queue expected values, a negedge monitor pops and compares.
module tb_gpio_port;

`ifdef GPIO_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    localparam int SEL_BUS = 0;
    localparam int SEL_OUT = 1;
    localparam int SEL_DIR = 2;
    localparam int SEL_REN = 3;
    localparam int SEL_INT = 4;

    logic        SysClock = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] MAB = 16'h0000;
    logic [15:0] MDB_in = 16'h0000;
    logic [15:0] MDB_out;
    logic        MW = 1'b0;
    logic        MR = 1'b0;
    logic        BW = 1'b0;
    logic [15:0] pad_in = 16'h0000;
    logic [15:0] pad_out;
    logic [15:0] padir;
    logic [15:0] paren;
    logic        int_p1;
    logic        int_p2;

    logic        obs_valid = 1'b0;
    int          obs_sel = 0;
    logic [15:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    gpio_port dut (
        .SysClock(SysClock),
        .rst_n(rst_n),
        .MAB(MAB),
        .MDB_in(MDB_in),
        .MDB_out(MDB_out),
        .MW(MW),
        .MR(MR),
        .BW(BW),
        .pad_in(pad_in),
        .pad_out(pad_out),
        .padir(padir),
        .paren(paren),
        .int_p1(int_p1),
        .int_p2(int_p2)
    );

    // Clock and watchdog
    always #5 SysClock = ~SysClock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    // Monitor: one pop per observation cycle, sampled away from the rising edge
    function automatic logic [15:0] observed(input int sel);
        case (sel)
            SEL_BUS: return MDB_out;
            SEL_OUT: return pad_out;
            SEL_DIR: return padir;
            SEL_REN: return paren;
            default: return {14'h0000, int_p2, int_p1};
        endcase
    endfunction

    always @(negedge SysClock) begin
        if (obs_valid) begin
            logic [15:0] exp_v;
            logic [15:0] act_v;
            string       nm;
            n_checks++;
            act_v = observed(obs_sel);
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty: got %h with no expected value queued", act_v);
            end else begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", nm, act_v, exp_v);
                end
            end
        end
    end

    // Driver tasks: each starts and ends just after a rising edge
    task automatic step(input int n);
        repeat (n) @(posedge SysClock);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data, input logic bw);
        MAB = addr; MDB_in = data; BW = bw; MW = 1'b1;
        step(1);
        MW = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] addr, input logic bw, input logic mr,
                            input logic [15:0] exp_v, input string nm);
        MAB = addr; BW = bw; MR = mr;
        exp_q.push_back(exp_v); name_q.push_back(nm);
        obs_sel = SEL_BUS; obs_valid = 1'b1;
        step(1);
        obs_valid = 1'b0; MR = 1'b0;
    endtask

    task automatic check_sig(input int sel, input logic [15:0] exp_v, input string nm);
        MAB = 16'h0000; BW = 1'b0;
        exp_q.push_back(exp_v); name_q.push_back(nm);
        obs_sel = sel; obs_valid = 1'b1;
        step(1);
        obs_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] regs[9];
        regs = '{16'h0200, 16'h0202, 16'h0204, 16'h0206, 16'h020E,
                 16'h0218, 16'h021A, 16'h021C, 16'h021E};
        step(3);
        rst_n = 1'b1;
        step(1);

        // Reset state
        foreach (regs[i]) bus_read(regs[i], 1'b0, 1'b0, 16'h0000, $sformatf("reset_reg_%h", regs[i]));
        check_sig(SEL_OUT, 16'h0000, "reset_pad_out");
        check_sig(SEL_DIR, 16'h0000, "reset_padir");
        check_sig(SEL_REN, 16'h0000, "reset_paren");
        check_sig(SEL_INT, 16'h0000, "reset_ints");

        // Register writes, byte lanes, illegal and unmapped accesses
        bus_write(16'h0204, 16'h00FF, 1'b0);
        bus_write(16'h0202, 16'hA5A5, 1'b0);
        check_sig(SEL_DIR, 16'h00FF, "padir_word");
        check_sig(SEL_OUT, 16'hA5A5, "pad_out_word");
        bus_write(16'h0205, 16'h003C, 1'b1);
        check_sig(SEL_DIR, 16'h3CFF, "padir_byte_hi");
        bus_read(16'h0205, 1'b1, 1'b0, 16'h003C, "padir_byte_read");
        bus_read(16'h0205, 1'b0, 1'b0, 16'h0000, "word_read_odd");
        bus_write(16'h0203, 16'hFFFF, 1'b0);
        check_sig(SEL_OUT, 16'hA5A5, "word_write_odd_ignored");
        bus_write(16'h0206, 16'h0F0F, 1'b0);
        check_sig(SEL_REN, 16'h0F0F, "paren_word");
        bus_read(16'h0300, 1'b0, 1'b0, 16'h0000, "unmapped_read");
        bus_write(16'h0200, 16'hFFFF, 1'b0);
        bus_read(16'h0200, 1'b0, 1'b0, 16'h0000, "pain_write_ignored");

        // Rising edge on P1.3
        bus_write(16'h021A, 16'h0008, 1'b0);
        pad_in = 16'h0008;
        step(LAT - 1);
        check_sig(SEL_INT, 16'h0000, "int_p1_before_latency");
        check_sig(SEL_INT, 16'h0001, "int_p1_at_latency");
        bus_read(16'h021C, 1'b0, 1'b0, 16'h0008, "paifg_p1_3");
        bus_read(16'h0200, 1'b0, 1'b0, 16'h0008, "pain_p1_3");
        bus_read(16'h020E, 1'b0, 1'b1, 16'h0008, "p1iv_bit3");
        bus_read(16'h021C, 1'b0, 1'b0, 16'h0000, "paifg_after_iv");
        check_sig(SEL_INT, 16'h0000, "int_p1_cleared");

        // Falling edges on P2.1 and P2.4
        bus_write(16'h0218, 16'h1200, 1'b0);
        pad_in = 16'h1208;
        step(LAT + 2);
        bus_read(16'h021C, 1'b0, 1'b0, 16'h0000, "rising_ignored_when_ies");
        bus_write(16'h021A, 16'h1200, 1'b0);
        pad_in = 16'h0008;
        step(LAT);
        check_sig(SEL_INT, 16'h0002, "int_p2_falling");
        bus_read(16'h021C, 1'b0, 1'b0, 16'h1200, "paifg_p2");
        bus_read(16'h021E, 1'b0, 1'b1, 16'h0004, "p2iv_first");
        bus_read(16'h021E, 1'b0, 1'b1, 16'h000A, "p2iv_second");
        bus_read(16'h021E, 1'b0, 1'b1, 16'h0000, "p2iv_empty");
        check_sig(SEL_INT, 16'h0000, "int_p2_cleared");

        // IV read clear colliding with a new edge on the same bit
        pad_in = 16'h0009;
        step(LAT);
        bus_read(16'h021C, 1'b0, 1'b0, 16'h0001, "paifg_bit0_set");
        pad_in = 16'h0008;
        step(LAT + 2);
        pad_in = 16'h0009;
        step(LAT - 1);
        bus_read(16'h020E, 1'b0, 1'b1, 16'h0002, "p1iv_collide_read");
        bus_read(16'h021C, 1'b0, 1'b0, 16'h0001, "edge_beats_iv_clear");
        bus_read(16'h020E, 1'b0, 1'b0, 16'h0002, "p1iv_peek");
        bus_read(16'h021C, 1'b0, 1'b0, 16'h0001, "peek_no_side_effect");
        bus_read(16'h020E, 1'b0, 1'b1, 16'h0002, "p1iv_clear_read");
        bus_read(16'h021C, 1'b0, 1'b0, 16'h0000, "paifg_bit0_cleared");

        // Software flag writes and IV-write clears
        bus_write(16'h021C, 16'h12FF, 1'b0);
        bus_read(16'h021C, 1'b0, 1'b0, 16'h12FF, "paifg_sw_write");
        check_sig(SEL_INT, 16'h0002, "int_from_sw_flags");
        bus_write(16'h020E, 16'h0000, 1'b0);
        bus_read(16'h021C, 1'b0, 1'b0, 16'h1200, "p1iv_write_clears_p1");
        bus_write(16'h021F, 16'h0000, 1'b1);
        bus_read(16'h021C, 1'b0, 1'b0, 16'h0000, "p2iv_write_clears_p2");
        bus_write(16'h021D, 16'h0080, 1'b1);
        bus_read(16'h021D, 1'b1, 1'b0, 16'h0080, "paifg_byte_hi");
        bus_read(16'h021E, 1'b0, 1'b0, 16'h0010, "p2iv_lowest_priority");

        // Asynchronous reset mid-operation
        rst_n = 1'b0;
        bus_read(16'h021C, 1'b0, 1'b0, 16'h0000, "reset_clears_flags");
        check_sig(SEL_OUT, 16'h0000, "reset_clears_pad_out");
        check_sig(SEL_DIR, 16'h0000, "reset_clears_padir");
        rst_n = 1'b1;
        step(2);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
